// File: rtl/gf180mcu_fd_sc_mcu7t5v0__and_tree_pipe_if.sv
// Sample bus of the pipelined AND-reduction tree: EN/VI/A/INV in, Z/VO out.
interface gf180mcu_fd_sc_mcu7t5v0__and_tree_pipe_if #(
   parameter int WIDTH = 16
);
   logic             EN;
   logic             VI;
   logic [WIDTH-1:0] A;
   logic             INV;
   logic             Z;
   logic             VO;

   modport master (output EN, VI, A, INV, input Z, VO);
   modport slave  (input EN, VI, A, INV, output Z, VO);
endinterface

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__and_tree_pipe.sv
// Pipelined wide AND/NAND reduction: WIDTH bits through a tree of RADIX-input
// AND nodes, optional register per level, valid and INV carried alongside.
module gf180mcu_fd_sc_mcu7t5v0__and_tree_pipe #(
   parameter int WIDTH = 16,
   parameter int RADIX = 4,
   parameter int PIPE  = 1
) (
   input logic CLK,
   input logic RN,
   gf180mcu_fd_sc_mcu7t5v0__and_tree_pipe_if.slave bus
);

   function automatic int nodes_at(input int k);
      int n;
      n = WIDTH;
      for (int i = 0; i < k; i++) n = (n + RADIX - 1) / RADIX;
      return n;
   endfunction

   function automatic int calc_levels();
      int n, l;
      n = WIDTH;
      l = 0;
      if (RADIX < 2) return 1;
      while (n > 1) begin
         n = (n + RADIX - 1) / RADIX;
         l++;
      end
      return (l < 1) ? 1 : l;
   endfunction

   localparam int LEVELS = calc_levels();

   if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
      $error("and_tree_pipe: WIDTH=%0d outside 1..64", WIDTH);
   end
   if (RADIX < 2 || RADIX > 4) begin : g_bad_radix
      $error("and_tree_pipe: RADIX=%0d outside 2..4", RADIX);
   end
   if (PIPE != 0 && PIPE != 1) begin : g_bad_pipe
      $error("and_tree_pipe: PIPE=%0d not 0 or 1", PIPE);
   end

   for (genvar k = 1; k <= LEVELS; k++) begin : lv
      localparam int NP = nodes_at(k - 1);
      localparam int N  = nodes_at(k);

      logic [NP-1:0]      src;
      logic               v_src;
      logic               i_src;
      logic [RADIX*N-1:0] pad;
      logic [N-1:0]       c;

      // Level input: raw bus, previous level's register, or previous level's logic
      if (k == 1) begin : g_src
         assign src   = bus.A;
         assign v_src = bus.VI;
         assign i_src = bus.INV;
      end else if (PIPE != 0) begin : g_src
         assign src   = lv[k-1].g_reg.q;
         assign v_src = lv[k-1].g_reg.v_q;
         assign i_src = lv[k-1].g_reg.i_q;
      end else begin : g_src
         assign src   = lv[k-1].c;
         assign v_src = lv[k-1].v_src;
         assign i_src = lv[k-1].i_src;
      end

      // Short last group is filled with 1s so it does not disturb the AND
      always_comb begin
         pad         = '1;
         pad[NP-1:0] = src;
      end

      for (genvar j = 0; j < N; j++) begin : nd
         assign c[j] = &pad[j*RADIX +: RADIX];
      end

      if (k == LEVELS) begin : g_out
         always_ff @(posedge CLK or negedge RN) begin
            if (!RN) begin
               bus.VO <= 1'b0;
               bus.Z  <= 1'b0;
            end else if (bus.EN) begin
               bus.VO <= v_src;
               if (v_src) bus.Z <= i_src ? ~c[0] : c[0];
            end
         end
      end else if (PIPE != 0) begin : g_reg
         logic [N-1:0] q;
         logic         v_q;
         logic         i_q;

         // Data and INV only load behind a valid sample; bubbles leave them idle
         always_ff @(posedge CLK or negedge RN) begin
            if (!RN) begin
               q   <= '0;
               v_q <= 1'b0;
               i_q <= 1'b0;
            end else if (bus.EN) begin
               v_q <= v_src;
               if (v_src) begin
                  q   <= c;
                  i_q <= i_src;
               end
            end
         end
      end
   end

endmodule

// File: doc/gf180mcu_fd_sc_mcu7t5v0__and_tree_pipe.md
Name: gf180mcu_fd_sc_mcu7t5v0__and_tree_pipe

Overview:
- Parametrised, pipelined wide-AND reduction for the mcu7t5v0 library.
- Successor to the fixed 4-input AND cell. Reduces WIDTH inputs through a tree of RADIX-input AND nodes, with an optional register after each tree level.
- Carries a valid bit and a per-sample NAND select alongside the data. Has a global stall.
- Used for wide match/compare and all-ones detection where a single-level AND cannot meet timing.

Parameters:
- WIDTH, 16, number of data inputs reduced; legal range 1..64.
- RADIX, 4, fan-in of each tree node; legal range 2..4.
- PIPE, 1, 1 = register after every tree level; 0 = combinational tree plus a single output register.

Ports:
- CLK  input  1  rising-edge clock.
- RN  input  1  asynchronous active-low reset.
- EN  input  1  pipeline advance enable; 0 = stall, all state held.
- VI  input  1  input sample valid.
- A  input  WIDTH  data bits to be reduced.
- INV  input  1  per-sample mode; 0 = AND result, 1 = NAND result.
- Z  output  1  registered reduction result.
- VO  output  1  Z holds a new result this cycle.

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-low, RN. RN=0 immediately forces every stage valid bit to 0, every stage data register to 0, every stored INV to 0, Z=0 and VO=0, independent of CLK. Release is taken on the next CLK edge; reset flushes any in-flight samples.
- Tree structure:
  - LEVELS = ceil(log_RADIX(WIDTH)), minimum 1; WIDTH=1 gives LEVELS=1, a registered buffer/inverter.
  - Level k combines groups of RADIX bits from level k-1. The last group of a level is padded with logic 1, so the AND identity is preserved.
  - Node count per level: ceil(prev/RADIX).
- Latency:
  - PIPE=1: exactly LEVELS enabled cycles from sampling A/VI/INV to Z/VO.
  - PIPE=0: exactly 1 enabled cycle.
  - Latency counts CLK edges with EN=1 only.
- Stage advance, on a CLK edge with EN=1:
  - Each stage valid bit takes the previous stage valid bit; stage 0 takes VI.
  - A stage's data register and INV copy load only when its incoming valid is 1. Otherwise they hold, which saves power.
  - Intermediate stages store plain AND partials.
  - INV is applied only at the final stage: Z = INV_final ? ~AND : AND.
- Output behaviour: VO equals the final stage valid bit. Z changes only on an edge where VO becomes or stays 1 with new data; with VO=0, Z holds the last result.
- Stall: on a CLK edge with EN=0, all registers hold, including Z and VO. VO=1 persists through the stall, and the downstream side must not double-count it. VI, A and INV are ignored while EN=0.
- Throughput: one sample per enabled cycle; back-to-back VI=1 gives back-to-back VO=1 in order. No backpressure other than EN.
- Simultaneous events: RN=0 overrides EN and VI. An EN=1 edge with VI=0 inserts a bubble, which propagates as VO=0 LEVELS cycles later.
- X handling: X on A while VI=0 must not reach Z.
- Elaboration checks: WIDTH or RADIX out of range, or PIPE not in {0,1}, causes an elaboration-time error.

Test Plan:
- Reset: WIDTH=16, RADIX=4, PIPE=1. Assert RN=0 mid-stream with two samples in flight -> Z=0 and VO=0 immediately, with no CLK edge needed. Nothing emerges after release until a new VI.
- Latency and function (LEVELS=2): A=16'hFFFF, VI=1, INV=0 at edge 0 -> VO=1, Z=1 after edge 2. A=16'hFFFE next cycle -> Z=0 after edge 3. A=16'hFFFE with INV=1 -> Z=1.
- Streaming with bubbles: VI pattern 1,0,1,1; A=FFFF, xxxx, 7FFF, FFFF -> VO pattern 1,0,1,1 delayed by 2 cycles. Z = 1, held 1, 0, 1.
- Stall: EN=0 for 3 cycles while a sample sits at stage 1 -> VO, Z and internal state frozen. Result appears 1 enabled cycle after EN returns to 1. A toggles during the stall with no effect.
- Padding: WIDTH=5, RADIX=4, PIPE=1 (LEVELS=2). A=5'b11111 -> Z=1. A=5'b01111 -> Z=0, which checks the padded partial group.
- PIPE=0 and WIDTH=1: PIPE=0, WIDTH=16 -> latency 1, same values as the latency scenario. WIDTH=1, A=0, INV=1 -> Z=1 after 1 edge.
